regbank_param: RTL and testbench
================================

Name: regbank_param

Overview:
- Parametrised successor to the 16x16 structural register bank.
- Address-decoded single write port; two combinational read ports with optional write-through bypass.
- Dedicated external-input register slot fed through a 2-flop synchroniser, loaded on a strobe.
- Multi-cycle clear-sweep state machine; sits between the ALU result bus and the operand-fetch stage of the CPU datapath.

Parameters:
WIDTH, 16, data width of each register
DEPTH, 16, number of registers (2..2^ADDR_W)
ADDR_W, 4, address width of read/write ports
INPUT_EN, 1, 1 = slot INPUT_IDX is the external-input register; 0 = ordinary register
INPUT_IDX, 5, index of external-input register (must be < DEPTH)
BYPASS, 1, 1 = read of the address being written this cycle returns wr_data

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
wr_en  input  1  write request (ALU bus write-back)
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data (ALU bus)
rd_addr_a  input  ADDR_W  read port A address
rd_data_a  output  WIDTH  read port A data (combinational)
rd_addr_b  input  ADDR_W  read port B address
rd_data_b  output  WIDTH  read port B data (combinational)
ext_in  input  WIDTH  asynchronous external input (player input)
ext_strobe  input  1  load synchronised ext_in into R[INPUT_IDX]
clr_req  input  1  start clear sweep
busy  output  1  high while clear sweep in progress
wr_err  output  1  one-cycle pulse: last write request rejected
ext_changed  output  1  one-cycle pulse: R[INPUT_IDX] loaded with a different value

Behaviour:
- Reset (reset=0, async): all R[i]=0, sync0=sync1=0, state=IDLE, sweep index=0, busy=0, wr_err=0, ext_changed=0.
- Write acceptance: accepted when wr_en=1, busy=0, wr_addr<DEPTH, and not (INPUT_EN=1 and wr_addr=INPUT_IDX). Accepted -> R[wr_addr]<=wr_data at next edge. Otherwise, if wr_en=1 -> wr_err=1 for the following cycle, no register changes.
- Reads: rd_data_x = R[rd_addr_x]; rd_addr_x>=DEPTH returns 0. If BYPASS=1 and the write this cycle is accepted with wr_addr=rd_addr_x, returns wr_data. Rejected writes are never bypassed. Reads are valid during busy.
- Synchroniser: sync0<=ext_in, sync1<=sync0 every cycle, unconditionally.
- Capture (INPUT_EN=1): if ext_strobe=1 at an edge, R[INPUT_IDX]<=sync1. ext_in change to R[INPUT_IDX] latency: 3 edges with strobe held high.
- ext_changed=1 for one cycle after a capture where sync1 differs from the old R[INPUT_IDX].
- FSM states: IDLE, CLEAR.
  - IDLE: clr_req=1 -> CLEAR, idx=0.
  - CLEAR: each edge R[idx]<=0, idx<=idx+1; at idx=DEPTH-1, clear that register and return to IDLE.
  - busy=1 exactly in CLEAR: DEPTH cycles. clr_req in CLEAR is ignored.
- Simultaneous sweep clear and capture on the same register: clear wins that cycle. Capture applies on all other cycles, including during CLEAR.
- Write during busy: rejected, wr_err pulses.
- Reset mid-sweep: immediate IDLE, all registers 0, busy=0.

Test Plan:
- Reset, write 0xBEEF to R3, read A=3 / B=3 next cycle -> both 0xBEEF; wr_err=0.
- BYPASS=1: wr_en=1, addr=7, data=0x1234 while rd_addr_a=7 in the same cycle -> rd_data_a=0x1234 before the edge, R7=0x1234 after.
- Write to addr 5 (INPUT_IDX) and to addr 16 with DEPTH=16, ADDR_W=5 -> both rejected, wr_err pulses once per request, R5 unchanged.
- ext_in=0x00A5, ext_strobe=1 -> R5=0x00A5 on the 3rd edge, ext_changed pulses once. Hold ext_in -> no further pulse.
- Fill R0..R15 with 0xFFFF (except R5), pulse clr_req -> busy high 16 cycles; writes in that window rejected; afterwards all reads return 0.
- Assert reset at sweep cycle 6 -> busy drops immediately, all registers read 0, a new clr_req is accepted after release.

Source files
------------

// File: rtl/regbank_param.sv
// Parameterised register bank: one write port, two combinational read ports with
// optional write-through, a synchronised external-input slot and a clear sweep.
module regbank_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter bit INPUT_EN  = 1'b1,
  parameter int INPUT_IDX = 5,
  parameter bit BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic [WIDTH-1:0]  ext_in,
  input  logic              ext_strobe,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err,
  output logic              ext_changed
);
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] IN_ADDR = ADDR_W'(INPUT_IDX);

  state_t                        state;
  logic [ADDR_W-1:0]             idx;
  logic [DEPTH-1:0][WIDTH-1:0]   regs;
  logic [WIDTH-1:0]              sync0, sync1;
  logic                          wr_ok, in_clr;

  assign busy   = (state == CLEAR);
  assign wr_ok  = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L) &&
                  !(INPUT_EN && (wr_addr == IN_ADDR));
  // The sweep owns the input slot on the cycle it reaches it.
  assign in_clr = busy && (idx == IN_ADDR);

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic [WIDTH-1:0] q;
    logic             clr_hit;
    assign clr_hit = busy && (idx == ADDR_W'(i));
    assign regs[i] = q;
    if (INPUT_EN && (i == INPUT_IDX)) begin : g_in
      always_ff @(posedge clk or negedge reset)
        if (!reset)          q <= '0;
        else if (clr_hit)    q <= '0;
        else if (ext_strobe) q <= sync1;
    end else begin : g_rw
      always_ff @(posedge clk or negedge reset)
        if (!reset)                                  q <= '0;
        else if (clr_hit)                            q <= '0;
        else if (wr_ok && (wr_addr == ADDR_W'(i)))   q <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_data_a = regs[i];
      if (rd_addr_b == ADDR_W'(i)) rd_data_b = regs[i];
    end
    if (BYPASS && wr_ok && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (BYPASS && wr_ok && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      sync0       <= '0;
      sync1       <= '0;
      wr_err      <= 1'b0;
      ext_changed <= 1'b0;
    end else begin
      sync0       <= ext_in;
      sync1       <= sync0;
      wr_err      <= wr_en && !wr_ok;
      ext_changed <= INPUT_EN && ext_strobe && !in_clr && (sync1 != regs[INPUT_IDX]);
      case (state)
        IDLE:
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
          end
        CLEAR:
          if (idx == LAST) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_regbank_param.sv
// Bench for regbank_param: vector table, hand sequences for capture/sweep/reset,
// then random traffic against a cycle-level behavioural model.
module tb_regbank_param;
  localparam int W = 16, D = 16, AW = 5, IDX = 5;

  logic          clk = 1'b0, reset = 1'b0;
  logic          wr_en = 1'b0, ext_strobe = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [W-1:0]  wr_data = '0, ext_in = '0;
  logic [W-1:0]  rd_data_a, rd_data_b;
  logic          busy, wr_err, ext_changed;

  always #5 clk = ~clk;

  regbank_param #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .INPUT_EN(1'b1),
                  .INPUT_IDX(IDX), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b), .ext_in(ext_in), .ext_strobe(ext_strobe),
    .clr_req(clr_req), .busy(busy), .wr_err(wr_err), .ext_changed(ext_changed));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register array, two-stage input pipe, sweep progress.
  logic [W-1:0] m [D];
  logic [W-1:0] s0, s1;
  bit           mbusy, merr, mchg;
  int           midx;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m[i] = '0;
    s0 = '0; s1 = '0; mbusy = 0; merr = 0; mchg = 0; midx = 0;
  endfunction

  function automatic bit m_acc();
    return wr_en && !mbusy && (int'(wr_addr) < D) && (int'(wr_addr) != IDX);
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_acc() && a == wr_addr) return wr_data;
    if (int'(a) < D) return m[int'(a)];
    return '0;
  endfunction

  function automatic void model_step();
    bit acc, cap;
    acc  = m_acc();
    cap  = ext_strobe && !(mbusy && midx == IDX);
    merr = wr_en && !acc;
    mchg = cap && (s1 != m[IDX]);
    if (acc) m[int'(wr_addr)] = wr_data;
    if (cap) m[IDX] = s1;
    if (mbusy) begin
      m[midx] = '0;
      midx++;
      if (midx == D) begin mbusy = 0; midx = 0; end
    end else if (clr_req) begin
      mbusy = 1; midx = 0;
    end
    s1 = s0;
    s0 = ext_in;
  endfunction

  task automatic model_compare();
    chk("rd_a", rd_data_a, exp_rd(rd_addr_a));
    chk("rd_b", rd_data_b, exp_rd(rd_addr_b));
    chk("busy", busy, mbusy);
    chk("wr_err", wr_err, merr);
    chk("ext_changed", ext_changed, mchg);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1 model_compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 0; ext_strobe = 0; clr_req = 0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; ext_in = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  typedef struct {
    logic we; logic [AW-1:0] wa; logic [W-1:0] wd; logic [AW-1:0] ra, rb;
    logic [W-1:0] ea, eb; logic eerr;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int cnt;
    tbl[0] = '{1'b1, 5'd3,  16'hBEEF, 5'd3,  5'd3,  16'hBEEF, 16'hBEEF, 1'b0};
    tbl[1] = '{1'b0, 5'd0,  16'h0000, 5'd3,  5'd3,  16'hBEEF, 16'hBEEF, 1'b0};
    tbl[2] = '{1'b1, 5'd7,  16'h1234, 5'd7,  5'd3,  16'h1234, 16'hBEEF, 1'b0};
    tbl[3] = '{1'b1, 5'd5,  16'h1111, 5'd7,  5'd5,  16'h1234, 16'h0000, 1'b0};
    tbl[4] = '{1'b1, 5'd16, 16'h2222, 5'd16, 5'd5,  16'h0000, 16'h0000, 1'b1};
    tbl[5] = '{1'b0, 5'd0,  16'h0000, 5'd5,  5'd16, 16'h0000, 16'h0000, 1'b1};
    tbl[6] = '{1'b0, 5'd0,  16'h0000, 5'd5,  5'd7,  16'h0000, 16'h1234, 1'b0};
    tbl[7] = '{1'b1, 5'd15, 16'hA5A5, 5'd15, 5'd31, 16'hA5A5, 16'h0000, 1'b0};

    @(negedge clk);
    reset = 0; idle_inputs(); model_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_ext_changed", ext_changed, 0);
    chk("rst_rd_a", rd_data_a, 0);
    @(posedge clk); @(negedge clk);
    reset = 1;

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
      #1;
      chk($sformatf("tbl%0d_rd_a", i), rd_data_a, tbl[i].ea);
      chk($sformatf("tbl%0d_rd_b", i), rd_data_b, tbl[i].eb);
      chk($sformatf("tbl%0d_wr_err", i), wr_err, tbl[i].eerr);
      step();
    end
    wr_en = 0;

    // External input capture: three edges through synchroniser and slot.
    do_reset();
    rd_addr_a = 5'd5; ext_in = 16'h00A5; ext_strobe = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("cap_r5_e%0d", k), rd_data_a, (k >= 3) ? 32'h00A5 : 32'h0);
      chk($sformatf("cap_chg_e%0d", k), ext_changed, (k == 3) ? 32'd1 : 32'd0);
    end
    ext_strobe = 0;

    // Fill, sweep, writes rejected while busy, everything reads zero after.
    for (int i = 0; i < D; i++) begin
      if (i == IDX) continue;
      wr_en = 1; wr_addr = AW'(i); wr_data = 16'hFFFF;
      step();
    end
    wr_en = 0; clr_req = 1;
    step();
    clr_req = 0;
    cnt = 0;
    while (busy && cnt < 40) begin
      wr_en = 1; wr_addr = AW'(cnt % D); wr_data = 16'h5555; clr_req = 1;
      step();
      cnt++;
    end
    chk("sweep_busy_cycles", cnt, D);
    chk("sweep_last_wr_err", wr_err, 1);
    wr_en = 0; clr_req = 0;
    for (int i = 0; i < D; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(D - 1 - i);
      #1 chk($sformatf("swept_r%0d", i), rd_data_a, 0);
      step();
    end

    // Reset in the middle of a sweep.
    wr_en = 1; wr_addr = 5'd3; wr_data = 16'h1234; step();
    wr_addr = 5'd12; wr_data = 16'hABCD; step();
    wr_en = 0; clr_req = 1; step();
    clr_req = 0;
    for (int k = 0; k < 6; k++) step();
    chk("pre_rst_busy", busy, 1);
    reset = 0; rd_addr_a = 5'd12; rd_addr_b = 5'd3;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_r12", rd_data_a, 0);
    chk("midrst_r3", rd_data_b, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1; clr_req = 1;
    step();
    clr_req = 0;
    chk("clr_after_rst", busy, 1);
    for (int k = 0; k < 20; k++) step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = AW'($urandom_range(0, D + 1));
      wr_data    = W'($urandom);
      rd_addr_a  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, D + 1));
      rd_addr_b  = AW'($urandom_range(0, D + 1));
      if ($urandom_range(0, 3) == 0) ext_in = W'($urandom);
      ext_strobe = ($urandom_range(0, 1) == 1);
      clr_req    = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
